fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, 32, width of all program-counter values.
REQ-002 Parameter IM_AW, 5, instruction-memory word-address width.
REQ-003 Parameter FQ_DEPTH, 4, fetch-queue entries; power of two, 2..16.
REQ-004 Parameter RESET_PC, 0, fetch PC after reset; bits [1:0] are zero.
REQ-005 Clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 ImAdress  output  IM_AW  word address to instruction memory, equal to FetchPc[IM_AW+1:2].
REQ-008 ImData  input  32  instruction word; combinational read of ImAdress.
REQ-009 Redirect  input  1  flush-and-redirect request (taken branch, jump).
REQ-010 RedirectPc  input  ADDR_W  target PC; bits [1:0] ignored, treated as 0.
REQ-011 InstrValid  output  1  Instr/InstrPc hold a valid fetched instruction.
REQ-012 InstrReady  input  1  consumer accepts Instr this cycle.
REQ-013 Instr  output  32  head instruction word.
REQ-014 InstrPc  output  ADDR_W  PC of the head instruction.
REQ-015 FqCount  output  log2(FQ_DEPTH)+1  current queue occupancy.

Function
REQ-016 Fetch PC register FetchPc; FIFO of FQ_DEPTH entries, each {PC, instruction}.
REQ-017 Pop = InstrValid && InstrReady; Push = (FqCount < FQ_DEPTH) || Pop; both evaluated in the same cycle.
REQ-018 On Push without Redirect: enqueue {FetchPc, ImData}; FetchPc <= FetchPc + 4, modulo 2^ADDR_W (wraps from all-ones-minus-3 to 0).
REQ-019 Full and Pop in the same cycle: push and pop both occur; FqCount unchanged.
REQ-020 Full and no Pop: no push; FetchPc holds; ImAdress stable.
REQ-021 InstrValid = (FqCount != 0); Instr/InstrPc drive the head entry; held stable while InstrValid && !InstrReady.
REQ-022 Redirect has priority over push and pop: on that edge queue emptied (FqCount <= 0), FetchPc <= {RedirectPc[ADDR_W-1:2], 2'b00}; ImData that cycle is discarded.
REQ-023 Pop occurring in the Redirect cycle is honoured by the consumer; the entry is not replayed.
REQ-024 Cycle after Redirect: ImAdress reflects target; first target instruction is pushed that cycle, visible at Instr one cycle later (fetch-to-Instr latency = 1 cycle).
REQ-025 Read/write pointers are log2(FQ_DEPTH) bits and wrap naturally; FqCount never exceeds FQ_DEPTH or underflows.
REQ-026 ImAdress uses FetchPc bits above IM_AW+1 are ignored (IM address wraps).

Reset
REQ-027 Reset asserted, at any time including mid-redirect: FetchPc <= RESET_PC, pointers and FqCount <= 0, InstrValid = 0 immediately (asynchronous).
REQ-028 Instr and InstrPc read 0 while Reset asserted; queue payload storage needs no reset.
REQ-029 First edge after Reset deassertion pushes the instruction at RESET_PC.

Configuration
REQ-030 Macro FETCH_BYPASS_EN.
REQ-031 Defined: when FqCount == 0 and no Redirect, InstrValid = 1 combinationally with Instr = ImData, InstrPc = FetchPc; if InstrReady, the word is consumed without being enqueued and FetchPc advances (0-cycle latency).
REQ-032 Defined: with bypass used, FqCount stays 0; an unaccepted bypass word is enqueued normally.
REQ-033 Not defined: no combinational path from ImData to Instr; behaviour exactly REQ-017..REQ-026.

Verification
REQ-034 Reset release, IM word n = 0x2000_0000+n, InstrReady=1 -> InstrPc sequence 0x0,0x4,0x8...; Instr 0x2000_0000,0x2000_0001,...; first valid 1 cycle after release (0 with FETCH_BYPASS_EN).
REQ-035 InstrReady=0 for 10 cycles, FQ_DEPTH=4 -> FqCount reaches 4, FetchPc holds at 0x10, Instr stays 0x2000_0000 at InstrPc 0x0.
REQ-036 Queue full, InstrReady=1 one cycle -> one pop and one push same edge, FqCount stays 4, next InstrPc 0x4.
REQ-037 Redirect=1, RedirectPc=0x0000_0043 with queue at 3 -> FqCount 0 next edge, next InstrPc 0x40, Instr = IM word 16.
REQ-038 RedirectPc=0xFFFF_FFFC, InstrReady=1 -> InstrPc 0xFFFF_FFFC then 0x0000_0000.
REQ-039 Reset pulsed mid-stream (asynchronous, between edges) -> InstrValid 0 within the same cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch PC plus {PC, instr} fetch queue with flush-on-redirect
// Optional macro FETCH_BYPASS_EN: present ImData directly when the queue is empty.
module fetch_unit #(
  parameter int ADDR_W   = 32,
  parameter int IM_AW    = 5,
  parameter int FQ_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         Clk,
  input  logic                         Reset,
  output logic [IM_AW-1:0]             ImAdress,
  input  logic [31:0]                  ImData,
  input  logic                         Redirect,
  input  logic [ADDR_W-1:0]            RedirectPc,
  output logic                         InstrValid,
  input  logic                         InstrReady,
  output logic [31:0]                  Instr,
  output logic [ADDR_W-1:0]            InstrPc,
  output logic [$clog2(FQ_DEPTH):0]    FqCount
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FQ_DEPTH);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW:0]       r_count;
  logic [ADDR_W-1:0] r_pc_mem    [FQ_DEPTH];
  logic [31:0]       r_instr_mem [FQ_DEPTH];

  logic w_bypass;
  logic w_qpop;
  logic w_push;
  logic w_enq;
  logic w_qvalid;

  assign w_qvalid = (r_count != '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = !w_qvalid && !Redirect;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_qpop = w_qvalid && InstrReady;
  assign w_push = (r_count < DEPTH_C) || w_qpop;
  // An accepted bypass word is consumed straight from ImData and never stored.
  assign w_enq  = w_push && !(w_bypass && InstrReady);

  assign ImAdress = r_fetch_pc[IM_AW+1:2];
  assign FqCount  = r_count;

`ifdef FETCH_BYPASS_EN
  assign InstrValid = !Reset && (w_qvalid || w_bypass);
  assign Instr      = Reset ? 32'd0 : (w_bypass ? ImData : r_instr_mem[r_rd_ptr]);
  assign InstrPc    = Reset ? '0 : (w_bypass ? r_fetch_pc : r_pc_mem[r_rd_ptr]);
`else
  assign InstrValid = !Reset && w_qvalid;
  assign Instr      = Reset ? 32'd0 : r_instr_mem[r_rd_ptr];
  assign InstrPc    = Reset ? '0 : r_pc_mem[r_rd_ptr];
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (Redirect) begin
      r_fetch_pc <= {RedirectPc[ADDR_W-1:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      end
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_qpop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_enq && !w_qpop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_enq && w_qpop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Payload storage carries no reset; validity comes only from r_count.
  always_ff @(posedge Clk) begin
    if (!Reset && !Redirect && w_enq) begin
      r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
      r_instr_mem[r_wr_ptr] <= ImData;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven directed bench for fetch_unit (default build)
module tb_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic [4:0]  ImAdress;
  logic [31:0] ImData;
  logic        Redirect;
  logic [31:0] RedirectPc;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [31:0] InstrPc;
  logic [2:0]  FqCount;

  int n_vec;
  int n_err;

  fetch_unit #(.ADDR_W(32), .IM_AW(5), .FQ_DEPTH(4), .RESET_PC(32'h0)) dut (
    .Clk(Clk), .Reset(Reset), .ImAdress(ImAdress), .ImData(ImData),
    .Redirect(Redirect), .RedirectPc(RedirectPc), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .Instr(Instr), .InstrPc(InstrPc), .FqCount(FqCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instruction memory: word n holds 0x2000_0000 + n.
  assign ImData = 32'h2000_0000 + {27'd0, ImAdress};

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] redir_pc;
    logic        ready;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [2:0]  exp_count;
    logic [4:0]  exp_addr;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    n_vec++;
    check($sformatf("v%0d valid", idx), {31'd0, InstrValid}, {31'd0, v.exp_valid});
    check($sformatf("v%0d count", idx), {29'd0, FqCount}, {29'd0, v.exp_count});
    check($sformatf("v%0d imaddr", idx), {27'd0, ImAdress}, {27'd0, v.exp_addr});
    if (v.chk_data) begin
      check($sformatf("v%0d instr_pc", idx), InstrPc, v.exp_pc);
      check($sformatf("v%0d instr", idx), Instr, v.exp_instr);
    end
  endtask

  initial begin
    //            rst  red  redpc         rdy  val  chk  pc            instr         cnt   addr
    vecs[0]  = '{1'b1,1'b0,32'h0,        1'b1,1'b0,1'b1,32'h0,        32'h0,        3'd0,5'h00};
    vecs[1]  = '{1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,        32'h0,        3'd0,5'h00};
    vecs[2]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,32'h0,        32'h2000_0000,3'd1,5'h01};
    vecs[3]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,32'h4,        32'h2000_0001,3'd1,5'h02};
    vecs[4]  = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h8,        32'h2000_0002,3'd1,5'h03};
    vecs[5]  = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h8,        32'h2000_0002,3'd2,5'h04};
    vecs[6]  = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h8,        32'h2000_0002,3'd3,5'h05};
    vecs[7]  = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h8,        32'h2000_0002,3'd4,5'h06};
    vecs[8]  = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h8,        32'h2000_0002,3'd4,5'h06};
    vecs[9]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,32'h8,        32'h2000_0002,3'd4,5'h06};
    vecs[10] = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'hC,        32'h2000_0003,3'd4,5'h07};
    vecs[11] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,32'hC,        32'h2000_0003,3'd4,5'h07};
    vecs[12] = '{1'b0,1'b1,32'h43,       1'b1,1'b1,1'b1,32'h10,       32'h2000_0004,3'd4,5'h08};
    vecs[13] = '{1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,        32'h0,        3'd0,5'h10};
    vecs[14] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,32'h40,       32'h2000_0010,3'd1,5'h11};
    vecs[15] = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h44,       32'h2000_0011,3'd1,5'h12};
    vecs[16] = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h44,       32'h2000_0011,3'd2,5'h13};
    vecs[17] = '{1'b0,1'b1,32'hFFFF_FFFC,1'b0,1'b1,1'b1,32'h44,       32'h2000_0011,3'd3,5'h14};
    vecs[18] = '{1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,        32'h0,        3'd0,5'h1F};
    vecs[19] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,32'hFFFF_FFFC,32'h2000_001F,3'd1,5'h00};
    vecs[20] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,32'h0,        32'h2000_0000,3'd1,5'h01};

    n_vec = 0;
    n_err = 0;
    Reset = 1'b1;
    Redirect = 1'b0;
    RedirectPc = 32'h0;
    InstrReady = 1'b0;

    for (int i = 0; i < 21; i++) begin
      @(negedge Clk);
      Reset      = vecs[i].rst;
      Redirect   = vecs[i].redir;
      RedirectPc = vecs[i].redir_pc;
      InstrReady = vecs[i].ready;
      #1;
      check_vec(i, vecs[i]);
    end

    // Asynchronous reset pulse between edges, released before the next edge.
    @(negedge Clk);
    Redirect = 1'b0;
    InstrReady = 1'b1;
    #2;
    n_vec++;
    check("pre_reset valid", {31'd0, InstrValid}, 32'd1);
    Reset = 1'b1;
    #1;
    n_vec++;
    check("async_reset valid", {31'd0, InstrValid}, 32'd0);
    check("async_reset count", {29'd0, FqCount}, 32'd0);
    check("async_reset instr", Instr, 32'h0);
    check("async_reset instr_pc", InstrPc, 32'h0);
    check("async_reset imaddr", {27'd0, ImAdress}, 32'd0);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    #1;
    n_vec++;
    check("restart valid", {31'd0, InstrValid}, 32'd1);
    check("restart instr_pc", InstrPc, 32'h0);
    check("restart instr", Instr, 32'h2000_0000);
    check("restart count", {29'd0, FqCount}, 32'd1);
    @(negedge Clk);
    #1;
    n_vec++;
    check("restart2 instr_pc", InstrPc, 32'h4);
    check("restart2 instr", Instr, 32'h2000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
